// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: hazard/EX control, instruction-memory port and IF/ID register outputs.
// The slave modport is the fetch stage; the master modport is the surrounding core or bench.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  stall_i;
  logic                  flush_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic [ADDR_WIDTH-1:0] im_addr_o;
  logic [31:0]           im_data_i;
  logic [ADDR_WIDTH-1:0] ifid_pc_o;
  logic [ADDR_WIDTH-1:0] ifid_pc4_o;
  logic [31:0]           ifid_instr_o;
  logic                  ifid_valid_o;
  logic                  fault_o;
  logic [ADDR_WIDTH-1:0] fault_pc_o;

  modport master (
    output stall_i, flush_i, redirect_i, redirect_pc_i, im_data_i,
    input  im_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
           fault_o, fault_pc_o
  );

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, im_data_i,
    output im_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
           fault_o, fault_pc_o
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32I IF stage: program counter, instruction fetch and IF/ID pipeline register.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirect targets halt the stage and raise a fault.
module instr_fetch_stage #(
  parameter int              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc4;
    logic [31:0]           instr;
    logic                  vld;
  } ifid_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam ifid_t IFID_BUBBLE = {{ADDR_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}, NOP_INSTR, 1'b0};

  function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(3);
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc_p0;
  ifid_t                 r_ifid_p1;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_redirect_tgt;
  logic                  w_misaligned;
  ifid_t                 w_fetched;

  assign w_pc_plus4 = r_pc_p0 + PC_STEP;
  assign w_fetched  = {r_pc_p0, w_pc_plus4, bus.im_data_i, 1'b1};

`ifdef IF_MISALIGN_TRAP_EN
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_fault_pc;

  assign w_redirect_tgt = bus.redirect_pc_i;
  assign w_misaligned   = is_misaligned(bus.redirect_pc_i);
  assign bus.fault_o    = r_fault;
  assign bus.fault_pc_o = r_fault_pc;
`else
  // Without the trap the low target bits are simply dropped, so HALT is never entered.
  assign w_redirect_tgt = align_word(bus.redirect_pc_i);
  assign w_misaligned   = 1'b0;
  assign bus.fault_o    = 1'b0;
  assign bus.fault_pc_o = '0;
`endif

  // p0: program counter / p1: IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc_p0   <= RESET_PC;
      r_ifid_p1 <= IFID_BUBBLE;
`ifdef IF_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (bus.redirect_i) begin
            r_ifid_p1 <= IFID_BUBBLE;
            if (w_misaligned) begin
              r_state <= HALT;
`ifdef IF_MISALIGN_TRAP_EN
              r_fault    <= 1'b1;
              r_fault_pc <= bus.redirect_pc_i;
`endif
            end else begin
              r_pc_p0 <= w_redirect_tgt;
            end
          end else if (bus.stall_i) begin
            if (bus.flush_i) r_ifid_p1 <= IFID_BUBBLE;
          end else if (bus.flush_i) begin
            r_ifid_p1 <= IFID_BUBBLE;
            r_pc_p0   <= w_pc_plus4;
          end else begin
            r_ifid_p1 <= w_fetched;
            r_pc_p0   <= w_pc_plus4;
          end
        end
        HALT: begin
          r_ifid_p1 <= IFID_BUBBLE;
        end
        default: begin
          r_state   <= RUN;
          r_ifid_p1 <= IFID_BUBBLE;
        end
      endcase
    end
  end

  assign bus.im_addr_o    = r_pc_p0;
  assign bus.ifid_pc_o    = r_ifid_p1.pc;
  assign bus.ifid_pc4_o   = r_ifid_p1.pc4;
  assign bus.ifid_instr_o = r_ifid_p1.instr;
  assign bus.ifid_valid_o = r_ifid_p1.vld;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed program-flow sequence plus random control traffic.
module tb_instr_fetch_stage;
  localparam int          AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0000;
      32'h0000_0004: return 32'h0198_06B3;
      32'h0000_0008: return 32'h0031_70B3;
      32'h0000_001C: return 32'h0094_8663;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign bus.im_data_i = imem(bus.im_addr_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        vld;
    logic        flt;
    logic [31:0] fpc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference machine state: where the stage fetches from, what sits in IF/ID, whether it is halted.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fpc;
  logic        m_vld, m_flt, m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      check("im_addr",    bus.im_addr_o,          e.pc);
      check("ifid_pc",    bus.ifid_pc_o,          e.ipc);
      check("ifid_pc4",   bus.ifid_pc4_o,         e.ipc4);
      check("ifid_instr", bus.ifid_instr_o,       e.instr);
      check("ifid_valid", {31'd0, bus.ifid_valid_o}, {31'd0, e.vld});
      check("fault",      {31'd0, bus.fault_o},   {31'd0, e.flt});
      check("fault_pc",   bus.fault_pc_o,         e.fpc);
    end
  end

  function automatic void bubble();
    m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_vld = 1'b0;
  endfunction

  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] rpc);
    exp_t e;
    rst = r; bus.stall_i = s; bus.flush_i = f; bus.redirect_i = rd; bus.redirect_pc_i = rpc;
    if (r) begin
      m_pc = RESET_PC; m_halt = 1'b0; m_flt = 1'b0; m_fpc = 0; bubble();
    end else if (m_halt) begin
      bubble();
    end else if (rd) begin
      bubble();
`ifdef IF_MISALIGN_TRAP_EN
      if (rpc % 4 != 0) begin
        m_halt = 1'b1; m_flt = 1'b1; m_fpc = rpc;
      end else m_pc = rpc;
`else
      m_pc = rpc - (rpc % 4);
`endif
    end else if (s) begin
      if (f) bubble();
    end else if (f) begin
      bubble();
      m_pc = m_pc + 4;
    end else begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = imem(m_pc); m_vld = 1'b1;
      m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
    e.vld = m_vld; e.flt = m_flt; e.fpc = m_fpc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    m_pc = 0; m_halt = 0; m_flt = 0; m_fpc = 0; bubble();

    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'h0000_0040);
    run(3);                                 // IF/ID: pc 0, 4, 8
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    run(1);                                 // IF/ID pc 12, PC 0x10
    step(0, 0, 0, 1, 32'h0000_001C);
    run(2);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 32'h0000_0040);
    run(2);
    step(0, 0, 1, 0, 0);
    run(1);
    step(0, 0, 0, 1, 32'h0000_001E);
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    step(1, 0, 0, 1, 32'h0000_0011);
    run(2);
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    run(2);                                 // PC wraps to 0
    step(0, 0, 0, 1, 32'h0000_0100);
    step(0, 0, 0, 1, 32'h0000_0200);        // back-to-back redirect: second wins
    run(2);

    for (int i = 0; i < 400; i++) begin
      logic        r, s, f, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 6) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
      step(r, s, f, rd, rpc);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
